// File: rtl/fp16_pkg.sv
// Shared half-precision types, constants and classification helper.
package fp16_pkg;

    localparam int FP16_BIAS    = 15;
    localparam int FP16_EXP_MAX = 31;
    localparam int FP16_FRAC_W  = 10;

    // One-hot class encoding; bit positions are part of the external interface.
    typedef enum logic [5:0] {
        ClsZero = 6'b000001,
        ClsSub  = 6'b000010,
        ClsNorm = 6'b000100,
        ClsInf  = 6'b001000,
        ClsQnan = 6'b010000,
        ClsSnan = 6'b100000
    } fp16_class_e;

    typedef struct packed {
        logic                   sign;
        logic [4:0]             exp;
        logic [FP16_FRAC_W-1:0] frac;
    } fp16_t;

    // Classify a packed word from its exponent and fraction fields.
    function automatic fp16_class_e fp16_classify(input fp16_t w);
        fp16_class_e cls;
        if (w.exp == 5'd0) begin
            cls = (w.frac == '0) ? ClsZero : ClsSub;
        end else if (w.exp == 5'(FP16_EXP_MAX)) begin
            if (w.frac == '0) begin
                cls = ClsInf;
            end else if (w.frac[FP16_FRAC_W-1]) begin
                cls = ClsQnan;
            end else begin
                cls = ClsSnan;
            end
        end else begin
            cls = ClsNorm;
        end
        return cls;
    endfunction

endpackage

// File: rtl/fp16_unpack_pipe_lzc10.sv
// 10-bit leading-zero counter; returns 10 for an all-zero input.
module fp16_lzc10 (
    input  logic [9:0] i_data,
    output logic [3:0] o_count
);

    // Scan upward so the highest set bit wins.
    always_comb begin
        o_count = 4'd10;
        for (int i = 0; i < 10; i++) begin
            if (i_data[i]) begin
                o_count = 4'(9 - i);
            end
        end
    end

endmodule

// File: rtl/fp16_unpack_pipe.sv
// Two-stage valid/ready decoder from packed half-precision to sign/exp/mant/class.
module fp16_unpack_pipe
    import fp16_pkg::*;
#(
    parameter int          BIAS  = FP16_BIAS,
    parameter int unsigned EXP_W = 7
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    flush,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [15:0]             in_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    out_sign,
    output logic signed [EXP_W-1:0] out_exp,
    output logic [10:0]             out_mant,
    output logic [5:0]              out_class
);

    localparam logic signed [EXP_W-1:0] BiasS   = EXP_W'(BIAS);
    localparam logic signed [EXP_W-1:0] SubBase = EXP_W'(1 - BIAS);
    localparam logic signed [EXP_W-1:0] OneS    = EXP_W'(1);

    fp16_t w_in;
    assign w_in = in_data;

    // Stage 1 state: raw fields plus class.
    logic        r_s1_valid;
    logic        r_s1_sign;
    logic [4:0]  r_s1_exp;
    logic [9:0]  r_s1_frac;
    logic [5:0]  r_s1_class;

    // Stage 2 state: drives the outputs directly.
    logic                    r_s2_valid;
    logic                    r_s2_sign;
    logic signed [EXP_W-1:0] r_s2_exp;
    logic [10:0]             r_s2_mant;
    logic [5:0]              r_s2_class;

    logic w_s1_rdy;
    logic w_s2_rdy;
    logic w_s1_take;
    logic w_s2_take;

    assign w_s2_rdy  = ~r_s2_valid | out_ready;
    assign w_s1_rdy  = ~r_s1_valid | w_s2_rdy;
    assign in_ready  = w_s1_rdy & ~flush;
    assign w_s1_take = in_valid & in_ready;
    assign w_s2_take = r_s1_valid & w_s2_rdy & ~flush;

    // Stage 1 register: capture fields and class on input transfer.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_s1_valid <= 1'b0;
            r_s1_sign  <= 1'b0;
            r_s1_exp   <= '0;
            r_s1_frac  <= '0;
            r_s1_class <= '0;
        end else begin
            if (flush) begin
                r_s1_valid <= 1'b0;
            end else if (w_s1_rdy) begin
                r_s1_valid <= in_valid;
            end
            if (w_s1_take) begin
                r_s1_sign  <= w_in.sign;
                r_s1_exp   <= w_in.exp;
                r_s1_frac  <= w_in.frac;
                r_s1_class <= fp16_classify(w_in);
            end
        end
    end

    logic [3:0]              w_lzc;
    logic signed [EXP_W-1:0] w_lzc_ext;
    logic signed [EXP_W-1:0] w_e_ext;
    logic signed [EXP_W-1:0] w_exp;
    logic [10:0]             w_mant;

    fp16_lzc10 u_lzc (
        .i_data  (r_s1_frac),
        .o_count (w_lzc)
    );

    assign w_lzc_ext = {{(EXP_W - 4){1'b0}}, w_lzc};
    assign w_e_ext   = {{(EXP_W - 5){1'b0}}, r_s1_exp};

    // Stage 2 datapath: unbias exponent and normalize significand per class.
    always_comb begin
        // Normal, inf and NaN share this path; E=31 yields 31-BIAS.
        w_exp  = w_e_ext - BiasS;
        w_mant = {1'b1, r_s1_frac};
        unique case (r_s1_class)
            ClsZero: begin
                w_exp  = '0;
                w_mant = '0;
            end
            ClsSub: begin
                w_exp  = SubBase - (w_lzc_ext + OneS);
                w_mant = {r_s1_frac, 1'b0} << w_lzc;
            end
            default: begin
            end
        endcase
    end

    // Stage 2 register: results held while the consumer stalls.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_s2_valid <= 1'b0;
            r_s2_sign  <= 1'b0;
            r_s2_exp   <= '0;
            r_s2_mant  <= '0;
            r_s2_class <= '0;
        end else begin
            if (flush) begin
                r_s2_valid <= 1'b0;
            end else if (w_s2_rdy) begin
                r_s2_valid <= r_s1_valid;
            end
            if (w_s2_take) begin
                r_s2_sign  <= r_s1_sign;
                r_s2_exp   <= w_exp;
                r_s2_mant  <= w_mant;
                r_s2_class <= r_s1_class;
            end
        end
    end

    assign out_valid = r_s2_valid;
    assign out_sign  = r_s2_sign;
    assign out_exp   = r_s2_exp;
    assign out_mant  = r_s2_mant;
    assign out_class = r_s2_class;

endmodule

// File: tb/tb_fp16_unpack_pipe.sv
// Scoreboard bench for fp16_unpack_pipe: directed vectors, stall, flush, reset and a sweep.
module tb_fp16_unpack_pipe;

    logic              clk = 1'b0;
    logic              reset_n;
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [15:0]       in_data;
    logic              out_valid;
    logic              out_ready;
    logic              out_sign;
    logic signed [6:0] out_exp;
    logic [10:0]       out_mant;
    logic [5:0]        out_class;

    always #5 clk = ~clk;

    fp16_unpack_pipe #(
        .BIAS  (15),
        .EXP_W (7)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sign  (out_sign),
        .out_exp   (out_exp),
        .out_mant  (out_mant),
        .out_class (out_class)
    );

    typedef struct {
        logic [15:0] word;
        logic        sign;
        int          exp;
        logic [10:0] mant;
        logic [5:0]  cls;
    } exp_t;

    exp_t q[$];
    exp_t dx[9];
    int   errors = 0;
    int   checks = 0;
    bit   done   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", name, act, req);
        end
    endtask

    function automatic exp_t mk(input logic s, input int x, input logic [10:0] m,
                                input logic [5:0] c);
        exp_t r;
        r.word = '0;
        r.sign = s;
        r.exp  = x;
        r.mant = m;
        r.cls  = c;
        return r;
    endfunction

    // Reference: subnormals normalized by shifting until bit 10 is set.
    function automatic exp_t model(input logic [15:0] w);
        exp_t        r;
        logic [4:0]  e;
        logic [9:0]  f;
        logic [10:0] m;
        int          x;
        e = w[14:10];
        f = w[9:0];
        if (e == 5'd0 && f == 10'd0) begin
            x = 0;
            m = '0;
            r = mk(w[15], x, m, 6'b000001);
        end else if (e == 5'd0) begin
            m = {1'b0, f};
            x = -14;
            while (!m[10]) begin
                m = m << 1;
                x = x - 1;
            end
            r = mk(w[15], x, m, 6'b000010);
        end else if (e == 5'd31) begin
            m = {1'b1, f};
            r = mk(w[15], 16, m, (f == 10'd0) ? 6'b001000 : (f[9] ? 6'b010000 : 6'b100000));
        end else begin
            x = int'(e) - 15;
            r = mk(w[15], x, {1'b1, f}, 6'b000100);
        end
        return r;
    endfunction

    // Present one word starting at a negedge; push its expectation when accepted.
    task automatic send(input logic [15:0] d, input exp_t e);
        int n   = 0;
        bit acc = 0;
        e.word   = d;
        in_valid = 1'b1;
        in_data  = d;
        while (!acc && n <= 500) begin
            #1;
            if (in_ready) begin
                q.push_back(e);
                acc = 1;
            end
            @(negedge clk);
            n++;
        end
        in_valid = 1'b0;
        checks++;
        if (!acc) begin
            errors++;
            $display("FAIL accept_timeout: word %h got no in_ready required in_ready=1", d);
        end
    endtask

    // Monitor: pop and compare whenever a result transfers downstream.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (reset_n && out_valid && out_ready) begin
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_output: got exp=%0d mant=%h class=%b required none",
                             out_exp, out_mant, out_class);
                end else begin
                    e = q.pop_front();
                    if (out_sign !== e.sign || int'(out_exp) != e.exp || out_mant !== e.mant ||
                        out_class !== e.cls) begin
                        errors++;
                        $display("FAIL word_%h: got s=%0d e=%0d m=%h c=%b required s=%0d e=%0d m=%h c=%b",
                                 e.word, out_sign, out_exp, out_mant, out_class,
                                 e.sign, e.exp, e.mant, e.cls);
                    end
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish required finish before timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        dx[0] = mk(1'b0,   0, 11'h400, 6'b000100);  // 3C00
        dx[1] = mk(1'b1,   2, 11'h500, 6'b000100);  // C500
        dx[2] = mk(1'b0, -24, 11'h400, 6'b000010);  // 0001
        dx[3] = mk(1'b1, -15, 11'h400, 6'b000010);  // 8200
        dx[4] = mk(1'b0, -15, 11'h7FE, 6'b000010);  // 03FF
        dx[5] = mk(1'b0,  16, 11'h400, 6'b001000);  // 7C00
        dx[6] = mk(1'b0,  16, 11'h600, 6'b010000);  // 7E00
        dx[7] = mk(1'b0,  16, 11'h401, 6'b100000);  // 7C01
        dx[8] = mk(1'b1,   0, 11'h000, 6'b000001);  // 8000

        reset_n   = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        #7;
        chk("reset_out_valid", out_valid, 0);
        chk("reset_out_sign", out_sign, 0);
        chk("reset_out_exp", out_exp, 0);
        chk("reset_out_mant", out_mant, 0);
        chk("reset_out_class", out_class, 0);
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        chk("in_ready_after_reset", in_ready, 1);
        @(negedge clk);

        // Directed vectors, free-flowing output.
        out_ready = 1'b1;
        send(16'h3C00, dx[0]);
        send(16'hC500, dx[1]);
        send(16'h0001, dx[2]);
        send(16'h8200, dx[3]);
        send(16'h03FF, dx[4]);
        send(16'h7C00, dx[5]);
        send(16'h7E00, dx[6]);
        send(16'h7C01, dx[7]);
        send(16'h8000, dx[8]);
        repeat (4) @(negedge clk);

        // Backpressure: A,B fill the pipe, C waits, then all drain in order.
        out_ready = 1'b0;
        fork
            begin
                send(16'h3C00, dx[0]);
                send(16'hC500, dx[1]);
                send(16'h0001, dx[2]);
            end
            begin
                repeat (2) @(negedge clk);
                for (int k = 0; k < 2; k++) begin
                    #1;
                    chk("stall_in_ready", in_ready, 0);
                    chk("stall_hold_valid", out_valid, 1);
                    chk("stall_hold_mant", out_mant, 11'h400);
                    chk("stall_hold_sign", out_sign, 0);
                    chk("stall_hold_class", out_class, 6'b000100);
                    @(negedge clk);
                end
                out_ready = 1'b1;
                for (int k = 0; k < 3; k++) begin
                    #1;
                    chk("drain_no_gap", out_valid, 1);
                    @(negedge clk);
                end
            end
        join
        repeat (2) @(negedge clk);

        // Flush with two words in flight and a word offered.
        out_ready = 1'b0;
        send(16'h7C00, dx[5]);
        send(16'h7E00, dx[6]);
        flush    = 1'b1;
        in_valid = 1'b1;
        in_data  = 16'h7C01;
        #1;
        chk("flush_pre_valid", out_valid, 1);
        chk("flush_in_ready", in_ready, 0);
        #2;
        q.delete();
        @(negedge clk);
        flush    = 1'b0;
        in_valid = 1'b0;
        #1;
        chk("flush_out_valid", out_valid, 0);
        out_ready = 1'b1;
        @(negedge clk);
        send(16'h8000, dx[8]);
        #1;
        chk("latency_cycle1", out_valid, 0);
        @(negedge clk);
        #1;
        chk("latency_cycle2", out_valid, 1);
        @(negedge clk);
        repeat (2) @(negedge clk);

        // Asynchronous reset mid-stream.
        out_ready = 1'b0;
        send(16'hC500, dx[1]);
        send(16'h8200, dx[3]);
        #1;
        chk("rst_pre_valid", out_valid, 1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("rst_async_valid", out_valid, 0);
        chk("rst_async_sign", out_sign, 0);
        chk("rst_async_exp", out_exp, 0);
        chk("rst_async_mant", out_mant, 0);
        chk("rst_async_class", out_class, 0);
        q.delete();
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        chk("rst_release_in_ready", in_ready, 1);
        out_ready = 1'b1;
        repeat (4) @(negedge clk);
        #1;
        chk("rst_no_stale", out_valid, 0);
        @(negedge clk);

        // Sweep every third encoding with random input gaps and output throttling.
        done = 0;
        fork
            begin
                for (int w = 0; w < 65536; w += 3) begin
                    if ($urandom_range(0, 3) == 0) begin
                        in_valid = 1'b0;
                        @(negedge clk);
                    end
                    send(16'(w), model(16'(w)));
                end
                done = 1;
            end
            begin
                while (!done) begin
                    out_ready = ($urandom_range(0, 3) != 0);
                    @(negedge clk);
                end
                out_ready = 1'b1;
            end
        join

        n = 0;
        while (q.size() != 0 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        chk("drain_empty", q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
